wb_writeback: RTL and testbench



---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_writeback_load_formatter.sv | 32 +++
 rtl/wb_writeback.sv | 97 +++++++++
 tb/tb_wb_writeback.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_WRITE     = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_writeback_load_formatter.sv
// Little-endian sub-word extraction and sign/zero extension for loads.
module load_formatter
    import wb_pkg::*;
(
    input  logic [WB_DATA_W-1:0] rdata,
    input  logic [1:0]           offset,
    input  logic [2:0]           load_type,
    output logic [WB_DATA_W-1:0] data
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[7:0];
        case (offset)
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            2'd3:    sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

        // Unknown encodings fall back to a full-word load.
        case (load_type)
            LT_LH:   data = {{(WB_DATA_W-16){sel_half[15]}}, sel_half};
            LT_LHU:  data = {{(WB_DATA_W-16){1'b0}}, sel_half};
            LT_LB:   data = {{(WB_DATA_W-8){sel_byte[7]}}, sel_byte};
            LT_LBU:  data = {{(WB_DATA_W-8){1'b0}}, sel_byte};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: retires MEM-stage instructions onto the register-file write port.
module wb_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_is_load,
    input  logic [2:0]        in_load_type,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_result,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wDin,
    output logic              wEna,
    output logic              load_pending,
    output logic [ADDR_W-1:0] load_pending_rd
);
    wb_state_t         state, state_next;
    logic [ADDR_W-1:0] cap_rd;
    logic              cap_rw;
    logic [2:0]        cap_lt;
    logic [1:0]        cap_off;
    logic [DATA_W-1:0] fmt_data;
    logic              accept;
    logic              alu_write;
    logic              load_write;

    load_formatter u_fmt (
        .rdata     (mem_rdata),
        .offset    (cap_off),
        .load_type (cap_lt),
        .data      (fmt_data)
    );

    assign in_ready     = (state != S_WAIT_LOAD);
    assign load_pending = (state == S_WAIT_LOAD);
    assign accept       = in_valid & in_ready;
    assign alu_write    = accept & ~in_is_load & in_reg_write & (in_rd != '0);
    assign load_write   = (state == S_WAIT_LOAD) & mem_rvalid & cap_rw & (cap_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_WRITE: begin
                if (accept) state_next = in_is_load ? S_WAIT_LOAD : S_WRITE;
                else        state_next = S_IDLE;
            end
            S_WAIT_LOAD: if (mem_rvalid) state_next = S_WRITE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Write-port outputs are registered at the accept/data edge so the write
    // lands in the following cycle; address and data only move on a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_rd          <= '0;
            cap_rw          <= 1'b0;
            cap_lt          <= LT_LW;
            cap_off         <= 2'd0;
            wEna            <= 1'b0;
            wAddr           <= '0;
            wDin            <= '0;
            load_pending_rd <= '0;
        end else begin
            wEna <= alu_write | load_write;
            if (accept) begin
                cap_rd <= in_rd;
                cap_rw <= in_reg_write;
                if (in_is_load) begin
                    cap_lt          <= in_load_type;
                    cap_off         <= in_result[1:0];
                    load_pending_rd <= in_rd;
                end
            end
            if (alu_write) begin
                wAddr <= in_rd;
                wDin  <= in_result;
            end else if (load_write) begin
                wAddr <= cap_rd;
                wDin  <= fmt_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_writeback.sv
// Randomized and directed checks of wb_writeback against a transaction-level model.
module tb_wb_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_load_type = 3'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_result = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [4:0]  wAddr;
    logic [31:0] wDin;
    logic        wEna;
    logic        load_pending;
    logic [4:0]  load_pending_rd;

    int n_chk = 0;
    int n_fail = 0;

    logic        exp_ena = 1'b0;
    logic [4:0]  exp_addr = 5'd0;
    logic [31:0] exp_din = 32'd0;

    wb_writeback dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_reg_write    (in_reg_write),
        .in_is_load      (in_is_load),
        .in_load_type    (in_load_type),
        .in_rd           (in_rd),
        .in_result       (in_result),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .wAddr           (wAddr),
        .wDin            (wDin),
        .wEna            (wEna),
        .load_pending    (load_pending),
        .load_pending_rd (load_pending_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference formatting from the load rules: pick a byte/halfword by address, then extend.
    function automatic logic [31:0] ref_format(input logic [31:0] word, input int lt, input int off);
        int unsigned b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            2: return h;
            3: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4: return b;
            default: return word;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_port(input string tag);
        chk({tag, ".wEna"}, {31'd0, wEna}, {31'd0, exp_ena});
        chk({tag, ".wAddr"}, {27'd0, wAddr}, {27'd0, exp_addr});
        chk({tag, ".wDin"}, wDin, exp_din);
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        cycle();
        exp_ena = 1'b0;
        check_port(tag);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // One instruction; leaves the bench at a negedge so the next call can follow back-to-back.
    task automatic txn(input string tag, input logic rw, input logic ld, input logic [2:0] lt,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rdata,
                       input int dly);
        chk({tag, ".ready_in"}, {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        in_reg_write = rw;
        in_is_load   = ld;
        in_load_type = lt;
        in_rd        = rd;
        in_result    = res;
        mem_rvalid   = 1'($urandom_range(0, 1));
        mem_rdata    = $urandom;
        cycle();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        if (!ld) begin
            exp_ena = rw && (rd != 0);
            if (exp_ena) begin
                exp_addr = rd;
                exp_din  = res;
            end
            check_port(tag);
            return;
        end
        exp_ena = 1'b0;
        for (int i = 0; i <= dly; i++) begin
            check_port({tag, ".wait"});
            chk({tag, ".ready_wait"}, {31'd0, in_ready}, 32'd0);
            chk({tag, ".pending"}, {31'd0, load_pending}, 32'd1);
            chk({tag, ".pending_rd"}, {27'd0, load_pending_rd}, {27'd0, rd});
            if (i < dly) cycle();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        cycle();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        exp_ena = rw && (rd != 0);
        if (exp_ena) begin
            exp_addr = rd;
            exp_din  = ref_format(rdata, int'(lt), int'(res[1:0]));
        end
        check_port(tag);
        chk({tag, ".ready_done"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".pending_done"}, {31'd0, load_pending}, 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".wEna"}, {31'd0, wEna}, 32'd0);
        chk({tag, ".wAddr"}, {27'd0, wAddr}, 32'd0);
        chk({tag, ".wDin"}, wDin, 32'd0);
        chk({tag, ".pending"}, {31'd0, load_pending}, 32'd0);
        chk({tag, ".pending_rd"}, {27'd0, load_pending_rd}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        w = 32'h80FF0011;

        @(negedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        idle("post_reset");

        txn("alu_rd5", 1'b1, 1'b0, 3'd0, 5'd5, 32'h12345678, 32'd0, 0);
        chk("alu_rd5.addr_const", {27'd0, wAddr}, 32'd5);
        chk("alu_rd5.din_const", wDin, 32'h12345678);
        idle("alu_rd5.after");

        txn("rd0", 1'b1, 1'b0, 3'd0, 5'd0, 32'hDEADBEEF, 32'd0, 0);
        idle("rd0.after");
        txn("rw0", 1'b0, 1'b0, 3'd0, 5'd7, 32'hCAFEF00D, 32'd0, 0);
        idle("rw0.after");

        txn("lb3", 1'b1, 1'b1, 3'd3, 5'd10, 32'h00001003, w, 0);
        chk("lb3.const", wDin, 32'hFFFFFF80);
        txn("lbu3", 1'b1, 1'b1, 3'd4, 5'd11, 32'h00001003, w, 1);
        chk("lbu3.const", wDin, 32'h00000080);
        txn("lh2", 1'b1, 1'b1, 3'd1, 5'd12, 32'h00001002, w, 0);
        chk("lh2.const", wDin, 32'hFFFF80FF);
        txn("lhu0", 1'b1, 1'b1, 3'd2, 5'd13, 32'h00001000, w, 2);
        chk("lhu0.const", wDin, 32'h00000011);
        txn("lw", 1'b1, 1'b1, 3'd0, 5'd14, 32'h00001003, w, 0);
        chk("lw.const", wDin, 32'h80FF0011);
        idle("loads.after");

        txn("stall_rd9", 1'b1, 1'b1, 3'd0, 5'd9, 32'h00002000, 32'h0BADF00D, 3);
        chk("stall_rd9.addr_const", {27'd0, wAddr}, 32'd9);
        idle("stall.after");

        txn("b2b_1", 1'b1, 1'b0, 3'd0, 5'd1, 32'h11111111, 32'd0, 0);
        txn("b2b_2", 1'b1, 1'b0, 3'd0, 5'd2, 32'h22222222, 32'd0, 0);
        txn("b2b_3", 1'b1, 1'b0, 3'd0, 5'd3, 32'h33333333, 32'd0, 0);
        chk("b2b_3.addr_const", {27'd0, wAddr}, 32'd3);
        idle("b2b.after");

        in_valid = 1'b1; in_reg_write = 1'b1; in_is_load = 1'b1;
        in_load_type = 3'd0; in_rd = 5'd9; in_result = 32'h00003000;
        cycle();
        in_valid = 1'b0;
        chk("rst_mid.pending", {31'd0, load_pending}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("rst_mid.asserted");
        cycle();
        rst_n = 1'b1;
        exp_ena = 1'b0; exp_addr = 5'd0; exp_din = 32'd0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        cycle();
        mem_rvalid = 1'b0;
        check_port("rst_mid.pulse");
        chk("rst_mid.pending", {31'd0, load_pending}, 32'd0);
        chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
        idle("rst_mid.after");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] res;
            res = $urandom;
            if ($urandom_range(0, 7) == 0) idle("rand_idle");
            txn("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), res, $urandom,
                int'($urandom_range(0, 3)));
        end
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
